frame_line_fetcher: RTL and testbench

//  Upstream pixel source for the VGA timing generator. Prefetches one image row at a time from

---
 rtl/frame_line_fetcher.sv | 129 ++++++++++++
 tb/tb_frame_line_fetcher.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/frame_line_fetcher.sv
// frame_line_fetcher: prefetches one image row per display line into a ping-pong line buffer
// and serves 8-bit grey pixels by column index.
//   clk, reset            pixel clock, asynchronous active-high reset
//   frame_start           restart fetching at row 0
//   line_start            hand the filled bank to the display side, start the next row
//   rd_en, rd_x           pixel read strobe and column -> pixel_out (1-cycle latency)
//   mem_req/addr/rdata/ack column-major memory read handshake, one pixel per ack
//   line_ready, busy      display bank valid, fill engine active
//   underrun              sticky: a line started before its row was fully fetched
module frame_line_fetcher #(
   parameter int IMG_W     = 300,
   parameter int IMG_H     = 300,
   parameter int BASE_ADDR = 300,
   parameter int ADDR_W    = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              line_start,
   input  logic              rd_en,
   input  logic [8:0]        rd_x,
   output logic [7:0]        pixel_out,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              line_ready,
   output logic              busy,
   output logic              underrun
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   // ABORT is the single idle request cycle that separates an underrun abort from the refill
   typedef enum logic [1:0] {IDLE, REQ, ABORT, DONE} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     fetch_row_q, fetch_row_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              fill_bank_q, fill_bank_d;
   logic              disp_bank_q, disp_bank_d;
   logic              line_ready_q, line_ready_d;
   logic              underrun_q, underrun_d;
   logic [7:0]        pixel_q, pixel_d;
   logic              wr_en;
   logic [RW:0]       nxt_row;
   logic              nxt_ok;
   logic [7:0]        ram [2][IMG_W];

   assign nxt_row = {1'b0, fetch_row_q} + (RW+1)'(1);
   assign nxt_ok  = nxt_row < (RW+1)'(IMG_H);

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      fetch_row_d  = fetch_row_q;
      mem_addr_d   = mem_addr_q;
      fill_bank_d  = fill_bank_q;
      disp_bank_d  = disp_bank_q;
      line_ready_d = line_ready_q;
      underrun_d   = underrun_q;
      wr_en        = 1'b0;
      if (frame_start) begin
         state_d      = REQ;
         col_d        = '0;
         fetch_row_d  = '0;
         mem_addr_d   = ADDR_W'(BASE_ADDR);
         fill_bank_d  = 1'b0;
         line_ready_d = 1'b0;
      end else if (line_start) begin
         line_ready_d = state_q == DONE;
         underrun_d   = underrun_q | (state_q == REQ) | (state_q == ABORT);
         if (state_q == DONE) begin
            disp_bank_d = fill_bank_q;
            fill_bank_d = ~fill_bank_q;
         end
         if (state_q != IDLE) begin
            // an aborted fill reuses its bank; a completed one moves to the other bank
            state_d     = !nxt_ok ? IDLE : (state_q == DONE) ? REQ : ABORT;
            col_d       = '0;
            fetch_row_d = nxt_ok ? nxt_row[RW-1:0] : fetch_row_q;
            mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(nxt_row);
         end
      end else if (state_q == ABORT) begin
         state_d = REQ;
      end else if (state_q == REQ && mem_ack) begin
         wr_en      = 1'b1;
         col_d      = col_q + CW'(1);
         mem_addr_d = mem_addr_q + ADDR_W'(IMG_W);
         state_d    = (col_q == CW'(IMG_W - 1)) ? DONE : REQ;
      end
      pixel_d = !rd_en ? pixel_q :
                (line_ready_q && 32'(rd_x) < IMG_W) ? ram[disp_bank_q][rd_x[CW-1:0]] : 8'h00;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         fetch_row_q  <= '0;
         mem_addr_q   <= '0;
         fill_bank_q  <= 1'b0;
         disp_bank_q  <= 1'b0;
         line_ready_q <= 1'b0;
         underrun_q   <= 1'b0;
         pixel_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         fetch_row_q  <= fetch_row_d;
         mem_addr_q   <= mem_addr_d;
         fill_bank_q  <= fill_bank_d;
         disp_bank_q  <= disp_bank_d;
         line_ready_q <= line_ready_d;
         underrun_q   <= underrun_d;
         pixel_q      <= pixel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) ram[fill_bank_q][col_q] <= mem_rdata;
   end

   assign mem_req    = state_q == REQ;
   assign mem_addr   = mem_addr_q;
   assign busy       = state_q != IDLE;
   assign line_ready = line_ready_q;
   assign underrun   = underrun_q;
   assign pixel_out  = pixel_q;
endmodule

// File: tb/tb_frame_line_fetcher.sv
// tb_frame_line_fetcher: small (4x2) and default (300x300) fetchers against a row-level model.
module tb_frame_line_fetcher;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       fs = '0, ls = '0, rd_en = '0, ack = '0;
   logic [1:0][8:0]  rd_x = '0;
   logic [1:0][7:0]  rdata = '0, pix;
   logic [1:0][23:0] addr;
   logic [1:0]       req, lr, busy, und;
   int               checks = 0, errors = 0, cyc = 0;
   int               mode [2] = '{0, 1};
   int               m_row [2], m_cnt [2], m_disp [2], m_pix [2];
   bit               m_gap [2], m_und [2];

   always #5 clk = ~clk;

   frame_line_fetcher #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(0), .ADDR_W(24)) u_small (
      .clk(clk), .reset(reset), .frame_start(fs[0]), .line_start(ls[0]), .rd_en(rd_en[0]),
      .rd_x(rd_x[0]), .pixel_out(pix[0]), .mem_req(req[0]), .mem_addr(addr[0]),
      .mem_rdata(rdata[0]), .mem_ack(ack[0]), .line_ready(lr[0]), .busy(busy[0]),
      .underrun(und[0]));

   frame_line_fetcher u_dflt (
      .clk(clk), .reset(reset), .frame_start(fs[1]), .line_start(ls[1]), .rd_en(rd_en[1]),
      .rd_x(rd_x[1]), .pixel_out(pix[1]), .mem_req(req[1]), .mem_addr(addr[1]),
      .mem_rdata(rdata[1]), .mem_ack(ack[1]), .line_ready(lr[1]), .busy(busy[1]),
      .underrun(und[1]));

   function automatic int pw(int i); return i == 0 ? 4 : 300; endfunction
   function automatic int ph(int i); return i == 0 ? 2 : 300; endfunction
   function automatic int pb(int i); return i == 0 ? 0 : 300; endfunction
   function automatic int mval(int a); return (a * 37 + 11) & 255; endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // memory: acks per mode (0 every cycle, 1 every third cycle), data is a function of address
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         ack[i]   = req[i] && (mode[i] == 0 || (mode[i] == 1 && cyc % 3 == 0));
         rdata[i] = 8'(mval(int'(addr[i])));
      end
   end

   // row-level model: which row is being fetched, how many pixels arrived, which row is shown
   always @(posedge clk) begin
      bit want;
      int nr;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_row[i] = -1; m_cnt[i] = 0; m_disp[i] = -1; m_gap[i] = 0; m_und[i] = 0; m_pix[i] = 0;
         end else begin
            want = m_row[i] >= 0 && !m_gap[i] && m_cnt[i] < pw(i);
            nr = m_row[i] + 1;
            if (rd_en[i])
               m_pix[i] = (m_disp[i] >= 0 && int'(rd_x[i]) < pw(i)) ?
                          mval(pb(i) + int'(rd_x[i]) * pw(i) + m_disp[i]) : 0;
            if (fs[i]) begin
               m_row[i] = 0; m_cnt[i] = 0; m_gap[i] = 0; m_disp[i] = -1;
            end else if (ls[i]) begin
               if (m_row[i] < 0) m_disp[i] = -1;
               else begin
                  if (m_cnt[i] == pw(i)) m_disp[i] = m_row[i];
                  else begin
                     m_und[i] = 1; m_disp[i] = -1; m_gap[i] = nr < ph(i);
                  end
                  m_row[i] = nr < ph(i) ? nr : -1;
                  m_cnt[i] = 0;
               end
            end else if (m_gap[i]) m_gap[i] = 0;
            else if (want && ack[i]) m_cnt[i]++;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         want = m_row[i] >= 0 && !m_gap[i] && m_cnt[i] < pw(i);
         chk($sformatf("mem_req[%0d]", i), 32'(req[i]), 32'(want));
         if (want) chk($sformatf("mem_addr[%0d]", i), 32'(addr[i]), pb(i) + m_cnt[i] * pw(i) + m_row[i]);
         chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_row[i] >= 0));
         chk($sformatf("line_ready[%0d]", i), 32'(lr[i]), 32'(m_disp[i] >= 0));
         chk($sformatf("underrun[%0d]", i), 32'(und[i]), 32'(m_und[i]));
         chk($sformatf("pixel_out[%0d]", i), 32'(pix[i]), m_pix[i]);
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      // T1: row 0 of the 4x2 image at addresses 0,4,8,12
      @(negedge clk) fs[0] = 1'b1;
      @(negedge clk) fs[0] = 1'b0;
      #1 chk("t1_addr0", 32'(addr[0]), 0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk) #1 chk("t1_addr", 32'(addr[0]), 4 * k);
      end
      @(negedge clk) #1;
      chk("t1_req_done", 32'(req[0]), 0);
      chk("t1_busy", 32'(busy[0]), 1);
      // T2: hand over row 0, fetch row 1 at 1,5,9,13, read row-0 column 2
      @(negedge clk) ls[0] = 1'b1;
      @(negedge clk) begin ls[0] = 1'b0; rd_en[0] = 1'b1; rd_x[0] = 9'd2; end
      #1 chk("t2_ready", 32'(lr[0]), 1);
      chk("t2_addr1", 32'(addr[0]), 1);
      @(negedge clk) rd_en[0] = 1'b0;
      #1 chk("t2_pix", 32'(pix[0]), 51);
      chk("t2_addr5", 32'(addr[0]), 5);
      @(negedge clk) #1 chk("t2_addr9", 32'(addr[0]), 9);
      @(negedge clk) #1 chk("t2_addr13", 32'(addr[0]), 13);
      // T5: last row handed over -> idle; then frame exhausted; then coincident restart
      @(negedge clk) ls[0] = 1'b1;
      @(negedge clk) begin ls[0] = 1'b0; rd_en[0] = 1'b1; rd_x[0] = 9'd3; end
      #1 chk("t5_busy", 32'(busy[0]), 0);
      chk("t5_req", 32'(req[0]), 0);
      chk("t5_ready", 32'(lr[0]), 1);
      @(negedge clk) begin rd_en[0] = 1'b0; ls[0] = 1'b1; end
      #1 chk("t5_pix_row1", 32'(pix[0]), 236);
      @(negedge clk) ls[0] = 1'b0;
      #1 chk("t5_exhausted", 32'(lr[0]), 0);
      @(negedge clk) begin fs[0] = 1'b1; ls[0] = 1'b1; end
      @(negedge clk) begin fs[0] = 1'b0; ls[0] = 1'b0; end
      #1 chk("t5_refetch_req", 32'(req[0]), 1);
      chk("t5_refetch_addr", 32'(addr[0]), 0);
      chk("t5_refetch_ready", 32'(lr[0]), 0);
      repeat (6) @(negedge clk);
      // T3: default image, slow memory, line starts before row 0 completes
      @(negedge clk) fs[1] = 1'b1;
      @(negedge clk) fs[1] = 1'b0;
      repeat (500) @(negedge clk);
      ls[1] = 1'b1;
      @(negedge clk) begin ls[1] = 1'b0; rd_en[1] = 1'b1; rd_x[1] = 9'd5; end
      #1 chk("t3_underrun", 32'(und[1]), 1);
      chk("t3_ready", 32'(lr[1]), 0);
      chk("t3_gap", 32'(req[1]), 0);
      @(negedge clk) begin rd_en[1] = 1'b0; mode[1] = 0; end
      #1 chk("t3_pix", 32'(pix[1]), 0);
      chk("t3_req", 32'(req[1]), 1);
      chk("t3_addr", 32'(addr[1]), 301);
      repeat (305) @(negedge clk);
      // T4: row 1 displayed; column 0 then the out-of-range column 300
      ls[1] = 1'b1;
      @(negedge clk) begin ls[1] = 1'b0; rd_en[1] = 1'b1; rd_x[1] = 9'd0; end
      #1 chk("t4_ready", 32'(lr[1]), 1);
      @(negedge clk) rd_x[1] = 9'd300;
      #1 chk("t4_pix_col0", 32'(pix[1]), 140);
      @(negedge clk) rd_x[1] = 9'd1;
      #1 chk("t4_pix_oob", 32'(pix[1]), 0);
      @(negedge clk) rd_en[1] = 1'b0;
      // T6: asynchronous reset in the middle of the row-2 fill
      #1 chk("t6_pre_pix", 32'(pix[1]), 232);
      chk("t6_pre_req", 32'(req[1]), 1);
      #2 reset = 1'b1;
      #1 chk("t6_req", 32'(req[1]), 0);
      chk("t6_pix", 32'(pix[1]), 0);
      chk("t6_underrun", 32'(und[1]), 0);
      chk("t6_ready", 32'(lr[1]), 0);
      chk("t6_busy", 32'(busy[1]), 0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
